counter_seq_ctrl: RTL and testbench

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_ctrl_pkg.sv | 26 ++
 rtl/counter_core.sv | 40 ++++
 rtl/counter_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the sequenced counter: FSM state encoding and
// the default counter width.
package counter_ctrl_pkg;

   localparam int CNT_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10,
      ST_DONE = 2'b11
   } ctrl_state_e;

   // Datapath operation requested by the controller for the coming edge.
   typedef enum logic [1:0] {
      ACT_FREEZE = 2'b00,
      ACT_CLEAR  = 2'b01,
      ACT_LOAD   = 2'b10,
      ACT_STEP   = 2'b11
   } core_act_e;

   function automatic logic is_busy_state(input ctrl_state_e st);
      return (st == ST_RUN) || (st == ST_HOLD);
   endfunction

endpackage

// File: rtl/counter_core.sv
// Loadable up/down counter datapath. Clear has priority over load, and
// load has priority over a count step.
module counter_core
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_en,
   input  logic             i_dir,
   output logic [WIDTH-1:0] o_value
);

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0] r_value;

   // Count register: clear, load, step down/up, or hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= ZERO;
      end else if (i_clr) begin
         r_value <= ZERO;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (i_en) begin
         r_value <= i_dir ? (r_value - ONE) : (r_value + ONE);
      end else begin
         r_value <= r_value;
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Start/stop/pause sequenced counter with one-shot or auto-reload modes.
// The controller never steps past terminal, so the count cannot wrap.
module counter_seq_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode,
   input  logic             dir,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt_out,
   output logic             busy,
   output logic             done,
   output logic             tc_pulse
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   ctrl_state_e      r_state;
   logic [WIDTH-1:0] r_limit;
   logic             r_dir;
   logic             r_mode;
   logic             r_tc;
   logic             r_busy;
   logic             r_done;

   ctrl_state_e      w_next_state;
   core_act_e        w_act;
   logic [WIDTH-1:0] w_load_val;
   logic             w_capture;
   logic             w_tc_next;
   logic             w_at_term;
   logic             w_core_dir;
   logic [WIDTH-1:0] w_cnt;

   assign w_at_term = r_dir ? (w_cnt == ZERO) : (w_cnt == r_limit);

   // Next-state and datapath command decode; stop outranks start outranks pause.
   always_comb begin
      w_next_state = r_state;
      w_act        = ACT_FREEZE;
      w_load_val   = r_dir ? r_limit : ZERO;
      w_capture    = 1'b0;
      w_tc_next    = 1'b0;
      if (stop) begin
         w_next_state = ST_IDLE;
         w_act        = ACT_CLEAR;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  w_capture    = 1'b1;
                  w_act        = ACT_LOAD;
                  w_load_val   = dir ? load_val : ZERO;
                  w_next_state = ST_RUN;
               end else begin
                  w_act        = ACT_FREEZE;
               end
            end
            ST_RUN: begin
               // Terminal action completes before a coincident pause is honoured.
               if (w_at_term) begin
                  w_tc_next = 1'b1;
                  if (r_mode) begin
                     w_act        = ACT_LOAD;
                     w_next_state = ST_RUN;
                  end else begin
                     w_act        = ACT_FREEZE;
                     w_next_state = ST_DONE;
                  end
               end else if (pause) begin
                  w_act        = ACT_FREEZE;
                  w_next_state = ST_HOLD;
               end else begin
                  w_act        = ACT_STEP;
                  w_next_state = ST_RUN;
               end
            end
            ST_HOLD: begin
               if (pause) begin
                  w_next_state = ST_HOLD;
               end else begin
                  w_next_state = ST_RUN;
               end
            end
            default: begin
               w_next_state = ST_IDLE;
               w_act        = ACT_CLEAR;
            end
         endcase
      end
   end

   assign w_core_dir = r_dir;

   counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_act == ACT_CLEAR),
      .i_load     (w_act == ACT_LOAD),
      .i_load_val (w_load_val),
      .i_en       (w_act == ACT_STEP),
      .i_dir      (w_core_dir),
      .o_value    (w_cnt)
   );

   // Controller state, start-time configuration and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_limit <= ZERO;
         r_dir   <= 1'b0;
         r_mode  <= 1'b0;
         r_tc    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_capture) begin
            r_limit <= load_val;
            r_dir   <= dir;
            r_mode  <= mode;
         end else begin
            r_limit <= r_limit;
            r_dir   <= r_dir;
            r_mode  <= r_mode;
         end
         r_tc    <= w_tc_next;
         r_busy  <= is_busy_state(w_next_state);
         r_done  <= (w_next_state == ST_DONE);
      end
   end

   assign cnt_out  = w_cnt;
   assign busy     = r_busy;
   assign done     = r_done;
   assign tc_pulse = r_tc;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed and randomized bench for counter_seq_ctrl against a flag-based
// behavioural model of the start/stop/pause counting rules.
module tb_counter_seq_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0, stop = 1'b0, pause = 1'b0, mode = 1'b0, dir = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] cnt_out;
   logic         busy, done, tc_pulse;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int m_cnt, m_limit;
   bit m_dir, m_mode, m_active, m_paused, m_done, m_tc;

   always #5 clk = ~clk;

   counter_seq_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
      .mode(mode), .dir(dir), .load_val(load_val),
      .cnt_out(cnt_out), .busy(busy), .done(done), .tc_pulse(tc_pulse)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_cnt = 0; m_limit = 0; m_dir = 0; m_mode = 0;
      m_active = 0; m_paused = 0; m_done = 0; m_tc = 0;
   endfunction

   function automatic void model_edge(bit st, bit sp, bit pa, bit md, bit dr, int lv);
      bit term;
      if (sp) begin
         m_active = 0; m_paused = 0; m_done = 0; m_cnt = 0; m_tc = 0;
      end else if (st && !m_active) begin
         m_limit = lv; m_dir = dr; m_mode = md;
         m_cnt = dr ? lv : 0;
         m_active = 1; m_paused = 0; m_done = 0; m_tc = 0;
      end else if (m_active && !m_paused) begin
         term = m_dir ? (m_cnt == 0) : (m_cnt == m_limit);
         if (term) begin
            m_tc = 1;
            if (m_mode) m_cnt = m_dir ? m_limit : 0;
            else begin m_active = 0; m_done = 1; end
         end else if (pa) begin
            m_paused = 1; m_tc = 0;
         end else begin
            m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
            m_tc = 0;
         end
      end else if (m_active && m_paused) begin
         if (!pa) m_paused = 0;
         m_tc = 0;
      end else begin
         m_tc = 0;
      end
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".cnt"},  int'(cnt_out),  m_cnt);
      chk({tag, ".busy"}, int'(busy),     int'(m_active));
      chk({tag, ".done"}, int'(done),     int'(m_done));
      chk({tag, ".tc"},   int'(tc_pulse), int'(m_tc));
   endtask

   task automatic step(input string tag, input bit st, input bit sp, input bit pa,
                       input bit md, input bit dr, input int lv);
      start = st; stop = sp; pause = pa; mode = md; dir = dr; load_val = W'(lv);
      @(posedge clk);
      model_edge(st, sp, pa, md, dr, lv);
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #2;
      check_all("reset_async");
      repeat (2) @(posedge clk);
      #1;
      check_all("reset_held");
      rst_n = 1'b1;
      step("idle", 0, 0, 0, 0, 0, 0);

      // Up, one-shot, limit 3.
      step("os_up_start", 1, 0, 0, 0, 0, 3);
      for (int i = 0; i < 6; i++) step("os_up", 0, 0, 0, 1, 1, 9);
      chk("os_up_done", int'(done), 1);
      chk("os_up_hold3", int'(cnt_out), 3);

      // Down, auto-reload, limit 2.
      step("ar_dn_start", 1, 0, 0, 1, 1, 2);
      for (int i = 0; i < 9; i++) step("ar_dn", 0, 0, 0, 0, 0, 7);
      chk("ar_dn_busy", int'(busy), 1);

      // Pause at count 2 for four cycles, limit 5.
      step("stop1", 0, 1, 0, 0, 0, 0);
      step("pause_start", 1, 0, 0, 0, 0, 5);
      step("pause_c1", 0, 0, 0, 0, 0, 0);
      step("pause_c2", 0, 0, 0, 0, 0, 0);
      chk("pause_at2", int'(cnt_out), 2);
      for (int i = 0; i < 4; i++) step("pause_hold", 0, 0, 1, 0, 0, 0);
      chk("pause_frozen", int'(cnt_out), 2);
      for (int i = 0; i < 6; i++) step("pause_resume", 0, 0, 0, 0, 0, 0);

      // Start ignored while running; stop beats start.
      step("prio_start", 1, 0, 0, 1, 0, 7);
      step("prio_run", 0, 0, 0, 0, 0, 0);
      step("prio_run", 0, 0, 0, 0, 0, 0);
      step("prio_ign", 1, 0, 0, 0, 1, 1);
      step("prio_run", 0, 0, 0, 0, 0, 0);
      step("prio_both", 1, 1, 0, 0, 0, 3);
      chk("prio_cnt0", int'(cnt_out), 0);
      chk("prio_idle", int'(busy), 0);

      // Auto-reload with limit 0.
      step("lim0_start", 1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step("lim0", 0, 0, 0, 0, 0, 0);
      chk("lim0_tc", int'(tc_pulse), 1);

      // Pause coinciding with terminal in auto-reload.
      step("stop2", 0, 1, 0, 0, 0, 0);
      step("tp_start", 1, 0, 0, 1, 0, 2);
      step("tp_c", 0, 0, 0, 0, 0, 0);
      step("tp_c", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("tp_pause", 0, 0, 1, 0, 0, 0);
      step("tp_rel", 0, 0, 0, 0, 0, 0);
      step("tp_c", 0, 0, 0, 0, 0, 0);

      // Asynchronous reset between edges at count 4.
      step("stop3", 0, 1, 0, 0, 0, 0);
      step("rst_start", 1, 0, 0, 0, 0, 9);
      for (int i = 0; i < 4; i++) step("rst_c", 0, 0, 0, 0, 0, 0);
      chk("rst_at4", int'(cnt_out), 4);
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_mid");
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step("rst_after", 0, 0, 0, 0, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
              $urandom_range(0, 15));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
